// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - shared BCD digit type, digit limits, reset times and load legality check
package bcd_time_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX     = 4'd9;
  localparam bcd_t TENS_MAX      = 4'd5;
  localparam bcd_t HOUR_TENS_MAX = 4'd2;
  localparam logic [7:0] HOUR_MAX_12 = 8'd12;
  localparam logic [7:0] HOUR_MAX_24 = 8'd23;

  localparam logic [23:0] RESET_TIME_12H = 24'h120000;
  localparam logic [23:0] RESET_TIME_24H = 24'h000000;

  // Afternoon test for a 24h-format BCD hour pair.
  function automatic logic bcd_hour_pm(input bcd_t hi, input bcd_t lo);
    return (hi > 4'd1) || (hi == 4'd1 && lo >= 4'd2);
  endfunction

  function automatic logic bcd_time_legal(input logic [23:0] t, input logic mode24);
    logic [7:0] hours;
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > DIGIT_MAX) ok = 1'b0;
    end
    if (t[15:12] > TENS_MAX || t[7:4] > TENS_MAX || t[23:20] > HOUR_TENS_MAX) ok = 1'b0;
    hours = 8'(t[23:20]) * 8'd10 + 8'(t[19:16]);
    if (mode24) begin
      if (hours > HOUR_MAX_24) ok = 1'b0;
    end else if (hours == 8'd0 || hours > HOUR_MAX_12) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit counting 0..MAX with synchronous load and ripple carry
module bcd_digit_counter
  import bcd_time_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic carry
);

  // Carry is combinational so a full ripple settles within one cycle.
  assign carry = inc && (q == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// rtl/bcd_time_keeper.sv - BCD HH:MM:SS time-of-day counter with prescaler, validated load and alarm
module bcd_time_keeper
  import bcd_time_pkg::*;
#(
  parameter bit          MODE_24H = 1'b0,
  parameter int unsigned PRESCALE = 1,
  parameter int          PS_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        load_pm,
  input  logic        alarm_en,
  input  logic [15:0] alarm_time,
  input  logic        alarm_pm,
  output bcd_t        h1,
  output bcd_t        h0,
  output bcd_t        m1,
  output bcd_t        m0,
  output bcd_t        s1,
  output bcd_t        s0,
  output logic        pm,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        alarm_hit,
  output logic        load_err
);

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [23:0]     RESET_TIME = MODE_24H ? RESET_TIME_24H : RESET_TIME_12H;

  logic [PS_W-1:0] ps_cnt;
  logic load_ok, load_bad, advance;
  logic s0_carry, s1_carry, m0_carry, m1_carry;
  bcd_t hn1, hn0, mn1, mn0, ah1, ah0;
  logic pmn, apm, load_pm_eff, alarm_match;

  assign load_ok  = load && bcd_time_legal(load_time, MODE_24H);
  assign load_bad = load && !load_ok;
  // Any load, accepted or not, swallows a coincident tick.
  assign advance  = tick_en && !load && (ps_cnt == PS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (load_ok) begin
      ps_cnt <= '0;
    end else if (tick_en && !load) begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
    end
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_s0 (
    .clk(clk), .reset(reset), .inc(advance), .ld(load_ok),
    .ld_val(load_time[3:0]), .q(s0), .carry(s0_carry)
  );
  bcd_digit_counter #(.MAX(TENS_MAX)) u_s1 (
    .clk(clk), .reset(reset), .inc(s0_carry), .ld(load_ok),
    .ld_val(load_time[7:4]), .q(s1), .carry(s1_carry)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_m0 (
    .clk(clk), .reset(reset), .inc(s1_carry), .ld(load_ok),
    .ld_val(load_time[11:8]), .q(m0), .carry(m0_carry)
  );
  bcd_digit_counter #(.MAX(TENS_MAX)) u_m1 (
    .clk(clk), .reset(reset), .inc(m0_carry), .ld(load_ok),
    .ld_val(load_time[15:12]), .q(m1), .carry(m1_carry)
  );

  // Next hour pair and pm, used when the minutes wrap.
  always_comb begin
    hn1 = h1;
    hn0 = h0;
    pmn = pm;
    if (MODE_24H) begin
      if (h1 == 4'd2 && h0 == 4'd3) begin
        hn1 = 4'd0;
        hn0 = 4'd0;
      end else if (h0 == DIGIT_MAX) begin
        hn1 = h1 + 4'd1;
        hn0 = 4'd0;
      end else begin
        hn0 = h0 + 4'd1;
      end
      pmn = bcd_hour_pm(hn1, hn0);
    end else begin
      if (h1 == 4'd1 && h0 == 4'd2) begin
        hn1 = 4'd0;
        hn0 = 4'd1;
      end else if (h1 == 4'd1 && h0 == 4'd1) begin
        hn1 = 4'd1;
        hn0 = 4'd2;
        pmn = !pm;
      end else if (h0 == DIGIT_MAX) begin
        hn1 = 4'd1;
        hn0 = 4'd0;
      end else begin
        hn0 = h0 + 4'd1;
      end
    end
  end

  // Alarm compares against the time the current advance is about to produce.
  assign mn0 = (m0 == DIGIT_MAX) ? 4'd0 : m0 + 4'd1;
  assign mn1 = (m0 == DIGIT_MAX) ? ((m1 == TENS_MAX) ? 4'd0 : m1 + 4'd1) : m1;
  assign ah1 = m1_carry ? hn1 : h1;
  assign ah0 = m1_carry ? hn0 : h0;
  assign apm = m1_carry ? pmn : pm;
  assign alarm_match = alarm_en && s1_carry && ({ah1, ah0, mn1, mn0} == alarm_time)
                       && (MODE_24H || (apm == alarm_pm));

  assign load_pm_eff = MODE_24H ? bcd_hour_pm(load_time[23:20], load_time[19:16]) : load_pm;

  always_ff @(posedge clk) begin
    if (reset) begin
      h1 <= RESET_TIME[23:20];
      h0 <= RESET_TIME[19:16];
      pm <= 1'b0;
    end else if (load_ok) begin
      h1 <= load_time[23:20];
      h0 <= load_time[19:16];
      pm <= load_pm_eff;
    end else if (m1_carry) begin
      h1 <= hn1;
      h0 <= hn0;
      pm <= pmn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= advance;
      min_pulse <= s1_carry;
      alarm_hit <= alarm_match;
      load_err  <= load_bad;
    end
  end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb/tb_bcd_time_keeper.sv - bench for bcd_time_keeper: 12h/P1, 24h/P1 and 12h/P4 against a seconds-of-day model
module tb_bcd_time_keeper;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset, tick_en, load, load_pm, alarm_en, alarm_pm;
  logic [23:0] load_time;
  logic [15:0] alarm_time;

  logic [3:0] h1 [N], h0 [N], m1 [N], m0 [N], s1 [N], s0 [N];
  logic       pm [N], sec_pulse [N], min_pulse [N], alarm_hit [N], load_err [N];
  logic [28:0] act [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_time_keeper #(.MODE_24H(g == 1), .PRESCALE(g == 2 ? 4 : 1), .PS_W(16)) u_dut (
      .clk(clk), .reset(reset), .tick_en(tick_en), .load(load), .load_time(load_time),
      .load_pm(load_pm), .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
      .h1(h1[g]), .h0(h0[g]), .m1(m1[g]), .m0(m0[g]), .s1(s1[g]), .s0(s0[g]),
      .pm(pm[g]), .sec_pulse(sec_pulse[g]), .min_pulse(min_pulse[g]),
      .alarm_hit(alarm_hit[g]), .load_err(load_err[g])
    );
    assign act[g] = {h1[g], h0[g], m1[g], m0[g], s1[g], s0[g], pm[g],
                     sec_pulse[g], min_pulse[g], alarm_hit[g], load_err[g]};
  end

  // Reference: time kept as seconds since midnight; display format derived on demand.
  int          tod [N];
  int          psc [N];
  logic [28:0] expv [N];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [24:0] disp(input int t, input bit m24);
    int hr, mn, sc;
    logic pmv;
    hr  = t / 3600;
    mn  = (t / 60) % 60;
    sc  = t % 60;
    pmv = (hr >= 12);
    if (!m24) hr = (hr % 12 == 0) ? 12 : hr % 12;
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), pmv};
  endfunction

  function automatic bit legal(input logic [23:0] t, input bit m24);
    int d [6];
    int hr;
    for (int k = 0; k < 6; k++) begin
      d[k] = int'(t[k*4 +: 4]);
      if (d[k] > 9) return 1'b0;
    end
    if (d[1] > 5 || d[3] > 5) return 1'b0;
    hr = d[5] * 10 + d[4];
    return m24 ? (hr <= 23) : (hr >= 1 && hr <= 12);
  endfunction

  function automatic int tod_of(input logic [23:0] t, input logic lpm, input bit m24);
    int hr;
    hr = int'(t[23:20]) * 10 + int'(t[19:16]);
    if (!m24) hr = hr % 12 + (lpm ? 12 : 0);
    return hr * 3600 + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60
           + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  task automatic model_step();
    bit m24, s, mi, al, er;
    int pre;
    logic [24:0] d;
    for (int i = 0; i < N; i++) begin
      m24 = (i == 1);
      pre = (i == 2) ? 4 : 1;
      s = 0; mi = 0; al = 0; er = 0;
      if (reset) begin
        tod[i] = 0;
        psc[i] = 0;
      end else if (load) begin
        if (legal(load_time, m24)) begin
          tod[i] = tod_of(load_time, load_pm, m24);
          psc[i] = 0;
        end else begin
          er = 1;
        end
      end else if (tick_en) begin
        if (psc[i] == pre - 1) begin
          psc[i] = 0;
          tod[i] = (tod[i] + 1) % 86400;
          s = 1;
          if (tod[i] % 60 == 0) begin
            mi = 1;
            d = disp(tod[i], m24);
            if (alarm_en && d[24:9] == alarm_time && (m24 || d[0] == alarm_pm)) al = 1;
          end
        end else begin
          psc[i] = psc[i] + 1;
        end
      end
      expv[i] = {disp(tod[i], m24), s, mi, al, er};
    end
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("model_dut%0d", i), 32'(act[i]), 32'(expv[i]));
  endtask

  task automatic set_in(input logic ld, input logic [23:0] lt, input logic lpm, input logic tk);
    load = ld; load_time = lt; load_pm = lpm; tick_en = tk;
  endtask

  typedef struct {
    logic        ld;
    logic [23:0] lt;
    logic        lpm;
    logic        tk;
    logic [23:0] et;
    logic        epm;
    logic        eerr;
  } vec_t;

  vec_t tbl [14];
  int   mins, r, hr, mn, sc;

  initial begin
    tbl[0]  = '{1'b1, 24'h115959, 1'b0, 1'b0, 24'h115959, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h120000, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 24'h125959, 1'b1, 1'b0, 24'h125959, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h010000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 24'h130000, 1'b0, 1'b0, 24'h010000, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 24'h016000, 1'b0, 1'b0, 24'h010000, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 24'h01000A, 1'b0, 1'b0, 24'h010000, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 24'h000000, 1'b0, 1'b0, 24'h010000, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 24'h240000, 1'b0, 1'b0, 24'h010000, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 24'h093000, 1'b0, 1'b1, 24'h093000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h093001, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 24'h120000, 1'b1, 1'b0, 24'h120000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 24'h115959, 1'b1, 1'b0, 24'h115959, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h120000, 1'b0, 1'b0};

    reset = 1'b1; alarm_en = 1'b0; alarm_pm = 1'b0; alarm_time = 16'h0000;
    set_in(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_12h", 32'(act[0]), 32'({24'h120000, 5'b0}));
    chk("reset_24h", 32'(act[1]), 32'({24'h000000, 5'b0}));
    reset = 1'b0;

    // 60 seconds from reset, one minute pulse on the last one
    mins = 0;
    for (int i = 0; i < 60; i++) begin
      set_in(1'b0, 24'h0, 1'b0, 1'b1);
      cycle();
      mins += int'(act[0][2]);
      if (i == 59) chk("min_pulse_on_60th", 32'(act[0][2]), 32'd1);
    end
    set_in(1'b0, 24'h0, 1'b0, 1'b0);
    chk("60_ticks_12h", 32'(act[0][28:4]), 32'({24'h120100, 1'b0}));
    chk("min_pulse_count", 32'(mins), 32'd1);
    chk("60_ticks_p4", 32'(act[2][28:4]), 32'({24'h120015, 1'b0}));
    chk("60_ticks_24h", 32'(act[1][28:4]), 32'({24'h000100, 1'b0}));

    foreach (tbl[k]) begin
      set_in(tbl[k].ld, tbl[k].lt, tbl[k].lpm, tbl[k].tk);
      cycle();
      chk($sformatf("tbl%0d", k), 32'({act[0][28:4], act[0][0]}),
          32'({tbl[k].et, tbl[k].epm, tbl[k].eerr}));
    end

    // 24h wrap, pm derivation, out-of-range hour
    set_in(1'b1, 24'h235959, 1'b0, 1'b0); cycle();
    chk("24h_load", 32'(act[1][28:4]), 32'({24'h235959, 1'b1}));
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle();
    chk("24h_wrap", 32'(act[1][28:2]), 32'({24'h000000, 1'b0, 1'b1, 1'b1}));
    set_in(1'b1, 24'h120000, 1'b0, 1'b0); cycle();
    chk("24h_noon_pm", 32'(act[1][28:4]), 32'({24'h120000, 1'b1}));
    set_in(1'b1, 24'h240000, 1'b0, 1'b0); cycle();
    chk("24h_bad_hour", 32'({act[1][28:4], act[1][0]}), 32'({24'h120000, 1'b1, 1'b1}));

    // Prescale by 4: load mid-count with a coincident tick
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle(); cycle();
    set_in(1'b1, 24'h010000, 1'b0, 1'b1); cycle();
    chk("p4_load_with_tick", 32'(act[2][28:3]), 32'({24'h010000, 1'b0, 1'b0}));
    set_in(1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    chk("p4_three_ticks", 32'(act[2][28:3]), 32'({24'h010000, 1'b0, 1'b0}));
    cycle();
    chk("p4_fourth_tick", 32'(act[2][28:3]), 32'({24'h010001, 1'b0, 1'b1}));

    // Alarm 07:30 PM
    alarm_en = 1'b1; alarm_time = 16'h0730; alarm_pm = 1'b1;
    set_in(1'b1, 24'h072959, 1'b1, 1'b0); cycle();
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle();
    chk("alarm_hit", 32'({act[0][28:4], act[0][1]}), 32'({24'h073000, 1'b1, 1'b1}));
    set_in(1'b0, 24'h0, 1'b0, 1'b0); cycle();
    chk("alarm_one_cycle", 32'(act[0][1]), 32'd0);
    set_in(1'b1, 24'h072959, 1'b0, 1'b0); cycle();
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle();
    chk("alarm_wrong_pm", 32'(act[0][1]), 32'd0);
    set_in(1'b1, 24'h072959, 1'b1, 1'b0); cycle();
    alarm_en = 1'b0;
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle();
    chk("alarm_disabled", 32'(act[0][1]), 32'd0);
    alarm_en = 1'b1;
    set_in(1'b1, 24'h073000, 1'b1, 1'b0); cycle();
    chk("alarm_not_on_load", 32'(act[0][1]), 32'd0);

    // Reset mid-count beats load and tick
    set_in(1'b0, 24'h0, 1'b0, 1'b1); cycle(); cycle(); cycle();
    reset = 1'b1;
    set_in(1'b1, 24'h105959, 1'b1, 1'b1); cycle();
    reset = 1'b0;
    chk("reset_mid_12h", 32'(act[0]), 32'({24'h120000, 5'b0}));
    chk("reset_mid_24h", 32'(act[1]), 32'({24'h000000, 5'b0}));

    for (int n = 0; n < 3000; n++) begin
      r       = int'($urandom_range(0, 999));
      reset   = (r < 3);
      tick_en = ($urandom_range(0, 9) < 7);
      load    = ($urandom_range(0, 99) < 4);
      load_pm = 1'($urandom_range(0, 1));
      alarm_pm = 1'($urandom_range(0, 1));
      alarm_en = ($urandom_range(0, 7) != 0);
      if (load) begin
        if ($urandom_range(0, 3) == 0) begin
          load_time = 24'($urandom);
        end else begin
          hr = int'($urandom_range(0, 23));
          mn = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 59));
          sc = int'($urandom_range(50, 59));
          load_time = {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
          alarm_time = {4'(hr / 10), 4'(hr % 10), 4'(((mn + 1) % 60) / 10), 4'((mn + 1) % 10)};
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
